// File: rtl/ul_sp_pkg.sv
// Shared types, widths and status-word layout for the triggered acquisition-window block.
package ul_sp_pkg;

  localparam int unsigned SAMPLE_W      = 16;
  localparam int unsigned PROD_W        = 2 * SAMPLE_W;
  localparam int unsigned TRIG_W        = 4;
  localparam int unsigned CTRL_W        = 128;
  localparam int unsigned STATUS_W      = 64;
  localparam int unsigned DELAY_W       = 16;
  localparam int unsigned FRAME_CNT_W   = 32;
  localparam int unsigned MISSED_W      = 16;
  localparam int unsigned FRAME_CNT_LSB = 0;
  localparam int unsigned MISSED_LSB    = 32;
  localparam int unsigned BUSY_BIT      = 48;

  localparam logic [SAMPLE_W-1:0] SAT_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_WINDOW = 2'd2
  } state_t;

  // One clock's worth of a channel: even and odd sample.
  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] xz;
  } pair_t;

  // Q15 power from a squared sample; the product is never negative, so only the top clamps.
  function automatic logic [SAMPLE_W-1:0] power_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> 15;
    if (|shifted[PROD_W-1:SAMPLE_W-1]) begin
      return SAT_MAX;
    end
    return shifted[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/user_logic_signal_processing_if.sv
// Sample, trigger, control/status and part-number bundle of the user-logic slot.
interface user_logic_signal_processing_if;
  import ul_sp_pkg::*;

  logic signed [SAMPLE_W-1:0] x0_i;
  logic signed [SAMPLE_W-1:0] x0z_i;
  logic signed [SAMPLE_W-1:0] x1_i;
  logic signed [SAMPLE_W-1:0] x1z_i;
  logic [TRIG_W-1:0]          trigger_vector_i;
  logic [CTRL_W-1:0]          user_register_i;

  logic signed [SAMPLE_W-1:0] y0_o;
  logic signed [SAMPLE_W-1:0] y0z_o;
  logic signed [SAMPLE_W-1:0] y1_o;
  logic signed [SAMPLE_W-1:0] y1z_o;
  logic [TRIG_W-1:0]          trigger_vector_o;
  logic [STATUS_W-1:0]        user_register_o;
  logic [SAMPLE_W-1:0]        ul_partnum_1_o;
  logic [SAMPLE_W-1:0]        ul_partnum_2_o;
  logic [SAMPLE_W-1:0]        ul_partnum_3_o;
  logic [SAMPLE_W-1:0]        ul_partnum_rev_o;

  modport master (
    output x0_i, x0z_i, x1_i, x1z_i, trigger_vector_i, user_register_i,
    input  y0_o, y0z_o, y1_o, y1z_o, trigger_vector_o, user_register_o,
    input  ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o
  );

  modport slave (
    input  x0_i, x0z_i, x1_i, x1z_i, trigger_vector_i, user_register_i,
    output y0_o, y0z_o, y1_o, y1z_o, trigger_vector_o, user_register_o,
    output ul_partnum_1_o, ul_partnum_2_o, ul_partnum_3_o, ul_partnum_rev_o
  );

endinterface

// File: rtl/ul_window_ctrl.sv
// Trigger-to-window sequencer: start delay, fixed-length window, frame and missed-trigger counters.
module ul_window_ctrl
  import ul_sp_pkg::*;
#(
  parameter int unsigned FRAME_PAIRS = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [TRIG_W-1:0]   trigger,
  input  logic [DELAY_W-1:0]  start_delay,
  output logic                in_window_c,
  output logic [STATUS_W-1:0] status
);

  localparam int unsigned    WIN_W    = (FRAME_PAIRS > 1) ? $clog2(FRAME_PAIRS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(FRAME_PAIRS - 1);

  state_t                 state, state_next;
  logic [DELAY_W-1:0]     delay_lat, delay_lat_next;
  logic [DELAY_W-1:0]     delay_cnt, delay_cnt_next;
  logic [WIN_W-1:0]       win_cnt, win_cnt_next;
  logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_next;
  logic [MISSED_W-1:0]    missed_cnt, missed_cnt_next;
  logic                   trig_event;

  // Any flagged sub-sample makes the whole cycle one trigger event.
  assign trig_event = |trigger;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      delay_lat  <= '0;
      delay_cnt  <= '0;
      win_cnt    <= '0;
      frame_cnt  <= '0;
      missed_cnt <= '0;
    end else begin
      state      <= state_next;
      delay_lat  <= delay_lat_next;
      delay_cnt  <= delay_cnt_next;
      win_cnt    <= win_cnt_next;
      frame_cnt  <= frame_cnt_next;
      missed_cnt <= missed_cnt_next;
    end
  end

  always_comb begin
    state_next      = state;
    delay_lat_next  = delay_lat;
    delay_cnt_next  = delay_cnt;
    win_cnt_next    = win_cnt;
    frame_cnt_next  = frame_cnt;
    missed_cnt_next = missed_cnt;
    in_window_c     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (trig_event) begin
          delay_lat_next = start_delay;
          delay_cnt_next = '0;
          win_cnt_next   = '0;
          state_next     = (start_delay == '0) ? ST_WINDOW : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (delay_cnt == delay_lat - DELAY_W'(1)) begin
          state_next   = ST_WINDOW;
          win_cnt_next = '0;
        end else begin
          delay_cnt_next = delay_cnt + DELAY_W'(1);
        end
      end
      ST_WINDOW: begin
        in_window_c = 1'b1;
        if (win_cnt == WIN_LAST) begin
          state_next     = ST_IDLE;
          frame_cnt_next = frame_cnt + FRAME_CNT_W'(1);
        end else begin
          win_cnt_next = win_cnt + WIN_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Triggers are never queued; while busy they only bump a saturating counter.
    if (trig_event && (state != ST_IDLE) && (missed_cnt != '1)) begin
      missed_cnt_next = missed_cnt + MISSED_W'(1);
    end
  end

  always_comb begin
    status                                 = '0;
    status[FRAME_CNT_LSB +: FRAME_CNT_W]   = frame_cnt;
    status[MISSED_LSB +: MISSED_W]         = missed_cnt;
    status[BUSY_BIT]                       = (state != ST_IDLE);
  end

endmodule

// File: rtl/user_logic_signal_processing.sv
// ADQ214 user-logic acquisition window: gates channel A to a triggered window, passes channel B.
// Define POWER_OUT_EN to output saturated Q15 instantaneous power on channel A inside the window.
module user_logic_signal_processing
  import ul_sp_pkg::*;
#(
  parameter int unsigned   FRAME_PAIRS = 512,
  parameter logic [15:0]   PARTNUM_1   = 16'h0001,
  parameter logic [15:0]   PARTNUM_2   = 16'h0002,
  parameter logic [15:0]   PARTNUM_3   = 16'h0003,
  parameter logic [15:0]   PARTNUM_REV = 16'h0001
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  user_logic_signal_processing_if.slave ul
);

`ifdef POWER_OUT_EN
  localparam int unsigned A_W = PROD_W;
`else
  localparam int unsigned A_W = SAMPLE_W;
`endif

  logic                in_window_c;
  logic [STATUS_W-1:0] status;
  logic                unused_ctrl;

  logic [A_W-1:0]      a_s1_d, az_s1_d;
  logic [A_W-1:0]      a_s1, az_s1;
  logic [SAMPLE_W-1:0] a_s2_d, az_s2_d;
  logic                win_s1;
  pair_t               b_s1;
  logic [TRIG_W-1:0]   trig_s1;

  ul_window_ctrl #(
    .FRAME_PAIRS (FRAME_PAIRS)
  ) u_window_ctrl (
    .clk         (clk_i),
    .rst         (rst_i),
    .trigger     (ul.trigger_vector_i),
    .start_delay (ul.user_register_i[DELAY_W-1:0]),
    .in_window_c (in_window_c),
    .status      (status)
  );

  // Only the start delay field of the control word is defined today.
  assign unused_ctrl = ^ul.user_register_i[CTRL_W-1:DELAY_W];

`ifdef POWER_OUT_EN
  // Square in stage 1, scale and clamp in stage 2 to keep the two-register latency.
  assign a_s1_d  = PROD_W'(ul.x0_i) * PROD_W'(ul.x0_i);
  assign az_s1_d = PROD_W'(ul.x0z_i) * PROD_W'(ul.x0z_i);
  assign a_s2_d  = power_sat(a_s1);
  assign az_s2_d = power_sat(az_s1);
`else
  assign a_s1_d  = ul.x0_i;
  assign az_s1_d = ul.x0z_i;
  assign a_s2_d  = a_s1;
  assign az_s2_d = az_s1;
`endif

  // Two-stage pipeline shared by every output stream; the window flag travels with channel A.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_s1                <= '0;
      az_s1               <= '0;
      win_s1              <= 1'b0;
      b_s1                <= '0;
      trig_s1             <= '0;
      ul.y0_o             <= '0;
      ul.y0z_o            <= '0;
      ul.y1_o             <= '0;
      ul.y1z_o            <= '0;
      ul.trigger_vector_o <= '0;
    end else begin
      a_s1                <= a_s1_d;
      az_s1               <= az_s1_d;
      win_s1              <= in_window_c;
      b_s1                <= '{x: ul.x1_i, xz: ul.x1z_i};
      trig_s1             <= ul.trigger_vector_i;
      ul.y0_o             <= win_s1 ? a_s2_d : '0;
      ul.y0z_o            <= win_s1 ? az_s2_d : '0;
      ul.y1_o             <= b_s1.x;
      ul.y1z_o            <= b_s1.xz;
      ul.trigger_vector_o <= trig_s1;
    end
  end

  assign ul.user_register_o  = status;
  assign ul.ul_partnum_1_o   = PARTNUM_1;
  assign ul.ul_partnum_2_o   = PARTNUM_2;
  assign ul.ul_partnum_3_o   = PARTNUM_3;
  assign ul.ul_partnum_rev_o = PARTNUM_REV;

endmodule

// File: tb/tb_user_logic_signal_processing.sv
// Directed + random bench for the acquisition window, checked cycle by cycle against a window-interval model.
module tb_user_logic_signal_processing;

  localparam int FRAME = 512;
  localparam int NCYC  = 8192;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  user_logic_signal_processing_if bus_if();

  user_logic_signal_processing #(
    .FRAME_PAIRS (FRAME)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .ul    (bus_if)
  );

  // Input history and per-cycle "inside window" truth from the model.
  logic [15:0] h_x0 [NCYC];
  logic [15:0] h_x0z[NCYC];
  logic [15:0] h_x1 [NCYC];
  logic [15:0] h_x1z[NCYC];
  logic [3:0]  h_trig[NCYC];
  logic        h_rst[NCYC];
  logic        h_win[NCYC];

  // Model: the active window is the closed cycle interval [win_start, win_end].
  longint      win_start, win_end;
  logic [31:0] m_frame;
  int          m_missed;

  logic [15:0]  d_x0, d_x0z, d_x1, d_x1z;
  logic [3:0]   d_trig;
  logic [127:0] d_ureg;
  logic         d_rst;

  int k;
  int n_pass;
  int n_total;
  int ramp;

  function automatic logic [15:0] chan_a(input logic [15:0] x, input logic win);
`ifdef POWER_OUT_EN
    int v;
`endif
    if (!win) return 16'h0000;
`ifdef POWER_OUT_EN
    v = int'($signed(x));
    v = (v * v) / 32768;
    if (v > 32767) v = 32767;
    return 16'(v);
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  task automatic rand_data();
    d_x0  = 16'($urandom);
    d_x0z = 16'($urandom);
    d_x1  = 16'($urandom);
    d_x1z = 16'($urandom);
  endtask

  // Apply one cycle of stimulus, advance the model, clock, and compare every output.
  task automatic tick();
    logic        live;
    logic        busy;
    logic [63:0] exp_status;
    rst                     = d_rst;
    bus_if.x0_i             = d_x0;
    bus_if.x0z_i            = d_x0z;
    bus_if.x1_i             = d_x1;
    bus_if.x1z_i            = d_x1z;
    bus_if.trigger_vector_i = d_trig;
    bus_if.user_register_i  = d_ureg;
    h_x0[k] = d_x0; h_x0z[k] = d_x0z; h_x1[k] = d_x1; h_x1z[k] = d_x1z;
    h_trig[k] = d_trig;
    h_rst[k]  = d_rst;
    h_win[k]  = (k >= win_start) && (k <= win_end);
    if (d_rst) begin
      win_start = 0;
      win_end   = -1;
      m_frame   = 0;
      m_missed  = 0;
    end else begin
      if (h_win[k] && (k == win_end)) m_frame++;
      if (d_trig != 4'b0) begin
        if (k <= win_end) begin
          if (m_missed < 65535) m_missed++;
        end else begin
          win_start = k + longint'(d_ureg[15:0]) + 1;
          win_end   = win_start + FRAME - 1;
        end
      end
    end
    busy = ((k + 1) <= win_end);
    exp_status = {15'd0, busy, 16'(m_missed), m_frame};

    @(posedge clk);
    #1;
    live = !d_rst && (k > 0) && !h_rst[k-1];
    check("y0",  64'($unsigned(bus_if.y0_o)),  live ? 64'(chan_a(h_x0[k-1],  h_win[k-1])) : 64'd0);
    check("y0z", 64'($unsigned(bus_if.y0z_o)), live ? 64'(chan_a(h_x0z[k-1], h_win[k-1])) : 64'd0);
    check("y1",  64'($unsigned(bus_if.y1_o)),  live ? 64'(h_x1[k-1])  : 64'd0);
    check("y1z", 64'($unsigned(bus_if.y1z_o)), live ? 64'(h_x1z[k-1]) : 64'd0);
    check("trig_o", 64'(bus_if.trigger_vector_o), live ? 64'(h_trig[k-1]) : 64'd0);
    check("status", bus_if.user_register_o, exp_status);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_data();
      tick();
    end
  endtask

  initial begin
    k = 0; n_pass = 0; n_total = 0;
    win_start = 0; win_end = -1; m_frame = 0; m_missed = 0;
    d_ureg = {$urandom, $urandom, $urandom, $urandom};

    // Reset held with busy-looking inputs.
    d_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      d_trig = 4'($urandom_range(1, 15));
      tick();
    end
    check("rst_status", bus_if.user_register_o, 64'd0);
    check("rst_y0", 64'($unsigned(bus_if.y0_o)), 64'd0);
    d_rst = 1'b0;
    d_trig = 4'b0;
    idle(5);

    check("partnum_1",   64'(bus_if.ul_partnum_1_o),   64'h0001);
    check("partnum_2",   64'(bus_if.ul_partnum_2_o),   64'h0002);
    check("partnum_3",   64'(bus_if.ul_partnum_3_o),   64'h0003);
    check("partnum_rev", 64'(bus_if.ul_partnum_rev_o), 64'h0001);

    // Window after a 16-cycle delay, ramp on channel A.
    d_ureg[15:0] = 16'd16;
    ramp = 1;
    for (int i = 0; i < 545; i++) begin
      rand_data();
      d_x0   = 16'(ramp);
      ramp++;
      d_trig = (i == 0) ? 4'b0001 : 4'b0000;
      tick();
    end
    check("win1_frame", 64'(bus_if.user_register_o[31:0]), 64'd1);
    check("win1_busy",  64'(bus_if.user_register_o[48]), 64'd0);

    // Retriggers while busy are dropped; control changes mid-window are ignored.
    d_ureg[15:0] = 16'd16;
    for (int i = 0; i < 700; i++) begin
      rand_data();
      case (i)
        0:       d_trig = 4'b0001;
        40:      d_trig = 4'b0100;
        80:      d_trig = 4'b1000;
        120:     d_trig = 4'b1000;
        default: d_trig = 4'b0000;
      endcase
      tick();
      if (i == 0) d_ureg = {$urandom, $urandom, $urandom, $urandom};
    end
    check("retrig_frame",  64'(bus_if.user_register_o[31:0]),  64'd2);
    check("retrig_missed", 64'(bus_if.user_register_o[47:32]), 64'd3);

    // Zero delay: window starts the cycle after the trigger; trigger output aligned.
    d_ureg[15:0] = 16'd0;
    rand_data(); d_trig = 4'b1000; tick();
    d_trig = 4'b0000;
    rand_data(); tick();
    check("d0_trig_align", 64'(bus_if.trigger_vector_o), 64'h8);
    idle(520);

    // Reset 100 cycles into a window, then a fresh full window.
    rand_data(); d_trig = 4'b0010; tick();
    d_trig = 4'b0000;
    idle(100);
    d_rst = 1'b1; rand_data(); tick();
    d_rst = 1'b0;
    check("midrst_y0", 64'($unsigned(bus_if.y0_o)), 64'd0);
    check("midrst_status", bus_if.user_register_o, 64'd0);
    idle(5);
    d_ureg[15:0] = 16'd3;
    rand_data(); d_trig = 4'b0100; tick();
    d_trig = 4'b0000;
    idle(520);
    check("postrst_frame", 64'(bus_if.user_register_o[31:0]), 64'd1);

`ifdef POWER_OUT_EN
    // Power scaling and saturation at the extremes.
    d_ureg[15:0] = 16'd0;
    rand_data(); d_trig = 4'b0001; tick();
    d_trig = 4'b0000;
    rand_data(); d_x0 = 16'h4000; tick();
    rand_data(); d_x0 = 16'h8000; tick();
    check("pwr_half", 64'($unsigned(bus_if.y0_o)), 64'h2000);
    rand_data(); tick();
    check("pwr_sat", 64'($unsigned(bus_if.y0_o)), 64'h7FFF);
    idle(520);
`endif

    // Random triggers, delays and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      d_trig = ($urandom_range(0, 149) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      d_ureg = {$urandom, $urandom, $urandom, $urandom};
      d_ureg[15:0] = 16'($urandom_range(0, 40));
      d_rst = ($urandom_range(0, 1499) == 0);
      tick();
    end
    d_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
